mem_dual_port_clr: RTL

//  Single-clock simple dual-port RAM (1 write port, 1 read port), generalised successor to the basic SDP memory.

---
 rtl/mem_dual_port_clr_pkg.sv | 30 +++
 rtl/mem_dual_port_clr_sequencer.sv | 68 ++++++
 rtl/mem_dual_port_clr.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mem_dual_port_clr_pkg.sv
// Shared types and helpers for the clearable simple dual-port RAM.
package mem_pkg;

    typedef enum logic {
        CLR_IDLE,
        CLR_SWEEP
    } clr_state_t;

    // Widest word lane_merge can handle; the top checks DATA_WIDTH against it.
    localparam int MEM_MAX_W     = 256;
    localparam int MEM_MAX_LANES = 256;

    // Bit i of the result comes from new_w when its lane (i / byte_w) is enabled.
    function automatic logic [MEM_MAX_W-1:0] lane_merge(
        input logic [MEM_MAX_W-1:0]     old_w,
        input logic [MEM_MAX_W-1:0]     new_w,
        input logic [MEM_MAX_LANES-1:0] be,
        input int unsigned              byte_w
    );
        logic [MEM_MAX_W-1:0] res;
        res = old_w;
        for (int unsigned i = 0; i < MEM_MAX_W; i++) begin
            if (be[8'(i / byte_w)]) begin
                res[8'(i)] = new_w[8'(i)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_dual_port_clr_sequencer.sv
// Clear sweep sequencer: walks every RAM entry once, one write per cycle.
//   state     | meaning
//   CLR_IDLE  | no sweep, user ports own the RAM
//   CLR_SWEEP | writing the fill value to entry cnt_q, busy high
module mem_clear_sequencer
    import mem_pkg::*;
#(
    parameter int  DEPTH          = 64,
    parameter bit  CLEAR_ON_RESET = 1'b1,
    localparam int AW             = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam clr_state_t    RST_STATE = CLEAR_ON_RESET ? CLR_SWEEP : CLR_IDLE;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    clr_state_t    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLR_IDLE: begin
                if (clear) begin
                    state_d = CLR_SWEEP;
                    cnt_d   = '0;
                end
            end
            CLR_SWEEP: begin
                // A new request restarts the walk so every entry is rewritten afterwards.
                if (clear) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_ADDR) begin
                    state_d = CLR_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = CLR_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q == CLR_SWEEP);
    assign clr_we   = busy;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/mem_dual_port_clr.sv
// Simple dual-port RAM with byte-lane writes, optional write-first forwarding,
// 0/1/2-cycle read pipeline and a hardware clear sweep.
module mem_dual_port_clr
    import mem_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    DEPTH          = 64,
    parameter int                    BYTE_WIDTH     = 8,
    parameter int                    OUTPUT_DELAY   = 1,
    parameter bit                    WRITE_FIRST    = 1'b1,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE  = '0,
    localparam int                   NUM_LANES      = DATA_WIDTH / BYTE_WIDTH,
    localparam int                   AW             = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  wea,
    input  logic [NUM_LANES-1:0]  bea,
    input  logic [AW-1:0]         addra,
    input  logic [DATA_WIDTH-1:0] dia,
    input  logic                  reb,
    input  logic [AW-1:0]         addrb,
    output logic [DATA_WIDTH-1:0] dob,
    output logic                  dob_valid
);

    if (!(OUTPUT_DELAY inside {0, 1, 2})) begin : g_bad_delay
        $error("mem_dual_port_clr: OUTPUT_DELAY must be 0, 1 or 2");
    end
    if (BYTE_WIDTH < 1 || (DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_lanes
        $error("mem_dual_port_clr: BYTE_WIDTH must divide DATA_WIDTH");
    end
    if (DATA_WIDTH >= MEM_MAX_W || DEPTH < 2) begin : g_bad_size
        $error("mem_dual_port_clr: DATA_WIDTH or DEPTH out of range");
    end

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic          clr_we;
    logic [AW-1:0] clr_addr;

    mem_clear_sequencer #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_seq (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic [DATA_WIDTH-1:0] ram_q [DEPTH];

    logic                  wr_in_range, rd_in_range;
    logic                  wr_acc, rd_acc;
    logic [AW-1:0]         wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] rd_raw, stage0;
    logic                  ram_we;
    logic [AW-1:0]         ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    logic [MEM_MAX_W-1:0]     new_ext, wr_old_ext, fwd_old_ext;
    logic [MEM_MAX_W-1:0]     wr_merged_ext, fwd_merged_ext;
    logic [MEM_MAX_LANES-1:0] be_ext;
    logic                     unused_merge_hi;

    assign wr_in_range = ({1'b0, addra} < DEPTH_W);
    assign rd_in_range = ({1'b0, addrb} < DEPTH_W);
    assign wr_acc      = wea & ~busy & wr_in_range;
    assign rd_acc      = reb & ~busy;
    // Clamp indices so out-of-range addresses never index past the array.
    assign wr_idx      = wr_in_range ? addra : '0;
    assign rd_idx      = rd_in_range ? addrb : '0;

    always_comb begin
        new_ext     = '0;
        wr_old_ext  = '0;
        fwd_old_ext = '0;
        be_ext      = '0;
        new_ext[DATA_WIDTH-1:0]     = dia;
        be_ext[NUM_LANES-1:0]       = bea;
        wr_old_ext[DATA_WIDTH-1:0]  = ram_q[wr_idx];
        rd_raw                      = rd_in_range ? ram_q[rd_idx] : DEFAULT_VALUE;
        fwd_old_ext[DATA_WIDTH-1:0] = rd_raw;
        wr_merged_ext  = lane_merge(wr_old_ext, new_ext, be_ext, BYTE_WIDTH);
        fwd_merged_ext = lane_merge(fwd_old_ext, new_ext, be_ext, BYTE_WIDTH);
        stage0 = rd_raw;
        if (WRITE_FIRST && wr_acc && (addra == addrb)) begin
            stage0 = fwd_merged_ext[DATA_WIDTH-1:0];
        end
    end

    assign unused_merge_hi = ^{wr_merged_ext[MEM_MAX_W-1:DATA_WIDTH],
                               fwd_merged_ext[MEM_MAX_W-1:DATA_WIDTH]};

    // The sweep owns the write port; busy already blocks wr_acc while it runs.
    assign ram_we    = clr_we | wr_acc;
    assign ram_waddr = clr_we ? clr_addr : wr_idx;
    assign ram_wdata = clr_we ? DEFAULT_VALUE : wr_merged_ext[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_waddr] <= ram_wdata;
        end
    end

    if (OUTPUT_DELAY == 0) begin : g_od0
        assign dob       = stage0;
        assign dob_valid = rd_acc;
    end else if (OUTPUT_DELAY == 1) begin : g_od1
        logic [DATA_WIDTH-1:0] s1_q, s1_d;
        logic                  v1_q, v1_d;

        always_comb begin
            s1_d = rd_acc ? stage0 : s1_q;
            v1_d = rd_acc;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1_q <= DEFAULT_VALUE;
                v1_q <= 1'b0;
            end else begin
                s1_q <= s1_d;
                v1_q <= v1_d;
            end
        end

        assign dob       = s1_q;
        assign dob_valid = v1_q;
    end else begin : g_od2
        logic [DATA_WIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
        logic                  v1_q, v1_d, v2_q, v2_d;

        always_comb begin
            s1_d = rd_acc ? stage0 : s1_q;
            v1_d = rd_acc;
            s2_d = s1_q;
            v2_d = v1_q;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1_q <= DEFAULT_VALUE;
                s2_q <= DEFAULT_VALUE;
                v1_q <= 1'b0;
                v2_q <= 1'b0;
            end else begin
                s1_q <= s1_d;
                s2_q <= s2_d;
                v1_q <= v1_d;
                v2_q <= v2_d;
            end
        end

        assign dob       = s2_q;
        assign dob_valid = v2_q;
    end

endmodule
